fpu_op_sequencer: RTL and testbench

- Control stage directly upstream of the FPU operand write-enable registers and the hardfloat core.
- Accepts one operation request (A, B, opcode) on a valid/ready handshake, drives the operand registers' data and write-enable, pulses the core start, and waits for done or a timeout.
- Holds the result and flags on a valid/ready response port until the consumer accepts them.
- Serialises operations: only one operation is in flight at a time.

---
 rtl/fpu_op_sequencer_if.sv | 38 +++
 rtl/fpu_op_sequencer.sv | 96 +++++++++
 tb/tb_fpu_op_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_op_sequencer_if.sv
// Request, operand-register, core and response signals of the FPU operation sequencer.
// master is the sequencer's view; slave is the surrounding environment's view.
interface fpu_op_sequencer_if #(
    parameter int SIZE = 32,
    parameter int OPW  = 4
);
    logic            req_valid;
    logic            req_ready;
    logic [SIZE-1:0] req_a;
    logic [SIZE-1:0] req_b;
    logic [OPW-1:0]  req_op;
    logic            opnd_we;
    logic [SIZE-1:0] opnd_a;
    logic [SIZE-1:0] opnd_b;
    logic [OPW-1:0]  opnd_op;
    logic            fpu_start;
    logic            fpu_done;
    logic [SIZE-1:0] fpu_result;
    logic [4:0]      fpu_flags;
    logic            res_valid;
    logic            res_ready;
    logic [SIZE-1:0] res_data;
    logic [4:0]      res_flags;
    logic            res_timeout;
    logic            busy;

    modport master (
        input  req_valid, req_a, req_b, req_op, fpu_done, fpu_result, fpu_flags, res_ready,
        output req_ready, opnd_we, opnd_a, opnd_b, opnd_op, fpu_start,
               res_valid, res_data, res_flags, res_timeout, busy
    );

    modport slave (
        output req_valid, req_a, req_b, req_op, fpu_done, fpu_result, fpu_flags, res_ready,
        input  req_ready, opnd_we, opnd_a, opnd_b, opnd_op, fpu_start,
               res_valid, res_data, res_flags, res_timeout, busy
    );
endinterface

// File: rtl/fpu_op_sequencer.sv
// Serialises FPU operations: loads operands, pulses the core start, waits for done
// (or times out) and holds the result on a valid/ready response port.
module fpu_op_sequencer #(
    parameter int SIZE    = 32,
    parameter int OPW     = 4,
    parameter int TIMEOUT = 64
) (
    input logic                clk,
    input logic                rst,
    fpu_op_sequencer_if.master bus
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] res_data_q, res_data_d;
    logic [4:0]      res_flags_q, res_flags_d;
    logic            res_timeout_q, res_timeout_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            res_data_q    <= '0;
            res_flags_q   <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            res_data_q    <= res_data_d;
            res_flags_q   <= res_flags_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        res_data_d      = res_data_q;
        res_flags_d     = res_flags_q;
        res_timeout_d   = res_timeout_q;

        bus.req_ready   = 1'b0;
        bus.opnd_we     = 1'b0;
        bus.fpu_start   = 1'b0;
        bus.res_valid   = 1'b0;
        bus.opnd_a      = SIZE'(bus.req_a);
        bus.opnd_b      = SIZE'(bus.req_b);
        bus.opnd_op     = OPW'(bus.req_op);
        bus.busy        = (state_q != IDLE);
        bus.res_data    = res_data_q;
        bus.res_flags   = res_flags_q;
        bus.res_timeout = res_timeout_q;

        case (state_q)
            IDLE: begin
                // Gated by rst so nothing is loaded into the operand registers during reset.
                bus.req_ready = !rst;
                if (bus.req_valid && !rst) begin
                    bus.opnd_we = 1'b1;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                bus.fpu_start = 1'b1;
                cnt_d         = '0;
                state_d       = WAIT;
            end
            WAIT: begin
                if (bus.fpu_done) begin
                    res_data_d    = bus.fpu_result;
                    res_flags_d   = bus.fpu_flags;
                    res_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_data_d    = '0;
                    res_flags_d   = '0;
                    res_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed and randomized checks of fpu_op_sequencer against a transaction-level reference.
module tb_fpu_op_sequencer;
    localparam int TO = 8;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fpu_op_sequencer_if #(.SIZE(32), .OPW(4)) bus();

    fpu_op_sequencer #(.SIZE(32), .OPW(4), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: an operation whose core answers within TIMEOUT wait cycles returns the core's
    // result; otherwise it returns a zeroed timeout response after exactly TIMEOUT wait cycles.
    task automatic model(input int done_dly, input logic [31:0] result, input logic [4:0] flags,
                         output logic [31:0] ed, output logic [4:0] ef, output logic et,
                         output int nwait);
        if (done_dly < TO) begin
            ed = result; ef = flags; et = 1'b0; nwait = done_dly + 1;
        end else begin
            ed = '0; ef = '0; et = 1'b1; nwait = TO;
        end
    endtask

    // Starts in an IDLE cycle (posedge+1), ends in the following IDLE cycle after the response.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input int done_dly, input logic [31:0] result, input logic [4:0] flags,
                          input int hold, input logic late_done);
        logic [31:0] ed;
        logic [4:0]  ef;
        logic        et;
        int          nwait;
        model(done_dly, result, flags, ed, ef, et, nwait);

        bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b; bus.req_op = op;
        #1;
        check("hs_ready", bus.req_ready, 1);
        check("hs_we", bus.opnd_we, 1);
        check("hs_a", bus.opnd_a, a);
        check("hs_b", bus.opnd_b, b);
        check("hs_op", bus.opnd_op, op);
        check("hs_start", bus.fpu_start, 0);

        next_cycle();
        bus.req_valid = 1'b0;
        #1;
        check("exec_start", bus.fpu_start, 1);
        check("exec_we", bus.opnd_we, 0);
        check("exec_busy", bus.busy, 1);
        check("exec_ready", bus.req_ready, 0);

        for (int k = 0; k < nwait; k++) begin
            next_cycle();
            bus.fpu_done   = (k == done_dly);
            bus.fpu_result = (k == done_dly) ? result : $urandom;
            bus.fpu_flags  = (k == done_dly) ? flags : 5'($urandom);
            #1;
            check("wait_valid", bus.res_valid, 0);
            check("wait_start", bus.fpu_start, 0);
            check("wait_busy", bus.busy, 1);
        end

        next_cycle();
        bus.fpu_done   = 1'b0;
        bus.fpu_result = $urandom;
        bus.fpu_flags  = 5'($urandom);
        for (int h = 0; h < hold; h++) begin
            bus.res_ready = 1'b0;
            bus.req_valid = 1'b1;
            bus.req_a     = $urandom;
            bus.fpu_done  = late_done;
            #1;
            check("hold_valid", bus.res_valid, 1);
            check("hold_data", bus.res_data, ed);
            check("hold_flags", bus.res_flags, ef);
            check("hold_to", bus.res_timeout, et);
            check("hold_ready", bus.req_ready, 0);
            check("hold_we", bus.opnd_we, 0);
            next_cycle();
        end
        bus.req_valid = 1'b0;
        bus.fpu_done  = 1'b0;
        bus.res_ready = 1'b1;
        #1;
        check("resp_valid", bus.res_valid, 1);
        check("resp_data", bus.res_data, ed);
        check("resp_flags", bus.res_flags, ef);
        check("resp_to", bus.res_timeout, et);

        next_cycle();
        bus.res_ready = 1'b0;
        #1;
        check("idle_busy", bus.busy, 0);
        check("idle_valid", bus.res_valid, 0);
        check("idle_ready", bus.req_ready, 1);
        check("idle_we", bus.opnd_we, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
        bus.fpu_done = 1'b0; bus.fpu_result = '0; bus.fpu_flags = '0; bus.res_ready = 1'b0;
        repeat (3) next_cycle();
        rst = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.res_valid, 0);
        check("rst_data", bus.res_data, 0);
        check("rst_flags", bus.res_flags, 0);
        check("rst_to", bus.res_timeout, 0);
        check("rst_start", bus.fpu_start, 0);
        check("rst_we", bus.opnd_we, 0);
        check("rst_ready", bus.req_ready, 1);

        // Basic op: done two cycles after start.
        run_op(32'h3F800000, 32'h40000000, 4'd0, 1, 32'h40400000, 5'b00000, 0, 1'b0);

        // Backpressure for 5 cycles, then the pending second request goes through.
        run_op(32'h11111111, 32'h22222222, 4'd3, 0, 32'hDEADBEEF, 5'b10100, 5, 1'b0);
        run_op(32'h33333333, 32'h44444444, 4'd5, 2, 32'hCAFEF00D, 5'b00010, 0, 1'b0);

        // Timeout with a late done during RESP, then a late done in IDLE.
        run_op(32'h55555555, 32'h66666666, 4'd7, TO + 4, 32'h12345678, 5'b11111, 2, 1'b1);
        bus.fpu_done = 1'b1; bus.fpu_result = 32'hFFFFFFFF; bus.fpu_flags = 5'b11111;
        #1;
        check("late_idle_we", bus.opnd_we, 0);
        next_cycle();
        bus.fpu_done = 1'b0;
        #1;
        check("late_idle_busy", bus.busy, 0);
        check("late_idle_valid", bus.res_valid, 0);
        check("late_idle_to", bus.res_timeout, 1);

        // Done in the same cycle the counter reaches TIMEOUT-1.
        run_op(32'h77777777, 32'h88888888, 4'd9, TO - 1, 32'h0BADCAFE, 5'b01000, 0, 1'b0);

        // Reset while waiting on the core.
        bus.req_valid = 1'b1; bus.req_a = 32'hA; bus.req_b = 32'hB; bus.req_op = 4'd1;
        next_cycle();
        bus.req_valid = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        check("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_valid", bus.res_valid, 0);
        check("mid_rst_ready", bus.req_ready, 1);
        run_op(32'h3F800000, 32'h3F800000, 4'd2, 0, 32'h40000000, 5'b00001, 0, 1'b0);

        // Back-to-back with done in the first wait cycle.
        for (int i = 0; i < 4; i++) begin
            run_op($urandom, $urandom, 4'(i), 0, 32'h1000 + i, 5'(1 << i), 0, 1'b0);
        end

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            run_op($urandom, $urandom, 4'($urandom), $urandom_range(0, TO + 3), $urandom,
                   5'($urandom), $urandom_range(0, 2), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
